// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
// Optional feature macro: PISO_PARITY_EN (adds a trailing even-parity bit).
package piso_pkg;

    // FSM states; PARITY is only reachable when PISO_PARITY_EN is defined.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

    // Width of the payload bit counter for a given word width.
    function automatic int PISO_CNT_W(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Modulo-WIDTH bit counter with synchronous clear, enable and a final-count flag.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clear,
    input  logic                        i_en,
    output logic [PISO_CNT_W(WIDTH)-1:0] o_cnt,
    output logic                        o_last
);

    localparam int CNT_W = PISO_CNT_W(WIDTH);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST_VAL);

    // Count enabled cycles, wrapping to zero after the final payload bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = w_last;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, MSB first, valid/ready load port.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit per word.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = PISO_CNT_W(WIDTH);

    piso_state_t      r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] w_cnt;
    logic             w_last;
    logic             w_in_idle;
    logic             w_in_shift;
    logic             w_final_bit;
    logic             w_load;

    assign w_in_idle   = (r_state == IDLE);
    assign w_in_shift  = (r_state == SHIFT);
    assign w_final_bit = w_in_shift && w_last;
    assign w_load      = load_valid && load_ready;

    // The counter restarts on every accepted word and advances once per payload bit.
    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_load),
        .i_en    (w_in_shift),
        .o_cnt   (w_cnt),
        .o_last  (w_last)
    );

`ifdef PISO_PARITY_EN
    logic r_parity;
    logic w_in_parity;

    assign w_in_parity = (r_state == PARITY);

    // Ready in IDLE and in the parity cycle, which is the true end of the frame.
    assign load_ready  = !rst && (w_in_idle || w_in_parity);
    assign sout        = w_in_shift ? r_shreg[WIDTH-1] : (w_in_parity & r_parity);
    assign sout_valid  = w_in_shift || w_in_parity;
    assign done        = w_in_parity;

    // Parity is latched with the word so the payload shift cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^din;
        end
    end
`else
    // Ready in IDLE and on the final payload bit, giving gap-free back-to-back words.
    assign load_ready  = !rst && (w_in_idle || w_final_bit);
    assign sout        = w_in_shift & r_shreg[WIDTH-1];
    assign sout_valid  = w_in_shift;
    assign done        = w_final_bit;
`endif

    assign busy = !w_in_idle;

    // FSM and shift register: load on handshake, shift MSB out each SHIFT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_shreg <= din;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
`ifdef PISO_PARITY_EN
                    r_shreg <= r_shreg << 1;
                    if (w_last) begin
                        r_state <= PARITY;
                    end
`else
                    if (w_last && w_load) begin
                        r_shreg <= din;
                    end else begin
                        r_shreg <= r_shreg << 1;
                        if (w_last) begin
                            r_state <= IDLE;
                        end
                    end
`endif
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    if (w_load) begin
                        r_shreg <= din;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_shreg <= '0;
                end
            endcase
        end
    end

    // The count value itself is only consumed through the last flag.
    logic w_cnt_unused;
    assign w_cnt_unused = ^w_cnt;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer (WIDTH=4); works with or without PISO_PARITY_EN.
module tb_piso_serializer;

    localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [WIDTH-1:0] din = '0;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .din        (din),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic d;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [3:0] rx = 4'b0;

    // Receiving shift-left register model fed by the serial stream.
    always @(posedge clk) begin
        if (sout_valid) rx <= {rx[2:0], sout};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected serial frame: payload MSB first, then the parity bit if enabled.
    task automatic push_frame(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            exp_t e;
            e.b = w[i];
            e.d = (i == 0) && !PAR;
            exp_q.push_back(e);
        end
        if (PAR) begin
            exp_t e;
            e.b = ^w;
            e.d = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: pops one expected entry per valid output bit.
    always @(posedge clk) begin
        #1;
        if (sout_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bit: got sout=%0b with empty queue at %0t", sout, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sout_bit", {31'b0, sout}, {31'b0, e.b});
                check("done_flag", {31'b0, done}, {31'b0, e.d});
                check("busy_during_bit", {31'b0, busy}, 32'd1);
            end
            $display("bit sout=%0b done=%0b t=%0t", sout, done, $time);
        end else if (done) begin
            checks++;
            errors++;
            $display("FAIL done_without_valid: got done=1 expected 0 at %0t", $time);
        end
    end

    // Offer a word at a negedge, hold it until accepted; returns after the handshake edge.
    task automatic send(input logic [WIDTH-1:0] w, output int waited, output logic done_at_acc);
        waited = 0;
        load_valid = 1'b1;
        din = w;
        while (!load_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!load_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: load_ready never rose for %b", w);
        end
        done_at_acc = done;
        push_frame(w);
        $display("load din=%b waited=%0d t=%0t", w, waited, $time);
        @(negedge clk);
    endtask

    task automatic go_idle();
        int n = 0;
        load_valid = 1'b0;
        din = '0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {31'b0, busy}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        logic d;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_sout", {31'b0, sout}, 32'd0);
        check("rst_valid", {31'b0, sout_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_ready_forced0", {31'b0, load_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'b0, load_ready}, 32'd1);

        // Single word 1100 plus loopback receiver check.
        send(4'b1100, w, d);
        load_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("loopback_rx", {28'b0, rx}, 32'hC);
        go_idle();
        check("ready_after_word", {31'b0, load_ready}, 32'd1);

        // Back-to-back 1010 then 0110.
        send(4'b1010, w, d);
        send(4'b0110, w, d);
        check("b2b_wait", w, PAR ? 32'd4 : 32'd3);
        check("b2b_no_gap", {31'b0, sout_valid}, 32'd1);
        go_idle();

        // Held load_valid during the second bit of 0001.
        send(4'b0001, w, d);
        load_valid = 1'b0;
        @(negedge clk);
        send(4'b1111, w, d);
        check("held_wait", w, PAR ? 32'd3 : 32'd2);
        check("held_accept_on_final", {31'b0, d}, 32'd1);
        go_idle();

        // Reset during the third bit of 1011.
        send(4'b1011, w, d);
        load_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_remaining", exp_q.size(), PAR ? 32'd2 : 32'd1);
        exp_q.delete();
        check("midrst_sout", {31'b0, sout}, 32'd0);
        check("midrst_valid", {31'b0, sout_valid}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_ready", {31'b0, load_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_midrst", {31'b0, load_ready}, 32'd1);
        repeat (6) @(negedge clk);

        // Parity-bearing frame 1011 (plain frame when parity is disabled).
        send(4'b1011, w, d);
        go_idle();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter: the sending end of the serial link whose receiver is the `shiftleftreg` serial-in/parallel-out register. It accepts a parallel word through a valid/ready handshake and emits it MSB-first, one bit per clock. A `shiftleftreg` receiving the stream reconstructs the original word after WIDTH edges. It includes a state machine, a bit counter, back-to-back loading and an optional parity bit.

## Interface
- `WIDTH`, default 4: word width in bits; legal range 2..32.
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  `din` holds a word to send.
- `load_ready`  out  1  block accepts a word this cycle.
- `din`  in  WIDTH  parallel word; sampled only on handshake.
- `sout`  out  1  serial data, MSB first.
- `sout_valid`  out  1  `sout` carries a payload or parity bit this cycle.
- `busy`  out  1  a word is in flight.
- `done`  out  1  one-cycle pulse coincident with the final bit of a word.

## Operation
- States: IDLE, SHIFT, PARITY. PARITY exists only with the macro defined.
- Handshake: a word transfers on a rising edge where `load_valid && load_ready`. `din` is ignored at all other times.
- `load_ready` = (state==IDLE) or (final-bit cycle). It is forced 0 while `rst`=1.
- IDLE: on handshake, `shreg <= din`, `cnt <= 0`, and the state moves to SHIFT.
- SHIFT:
  - `sout = shreg[WIDTH-1]` and `sout_valid = 1`.
  - Each edge: `shreg <= shreg << 1` (zero fill) and `cnt <= cnt + 1`.
  - `cnt` is $clog2(WIDTH) bits wide. `cnt == WIDTH-1` marks the final payload bit.
- Final payload bit, without the macro:
  - `done = 1`.
  - If a handshake occurs, reload and stay in SHIFT. Otherwise go to IDLE.
- Final payload bit, with the macro: go to PARITY. `load_ready` stays 0 on this cycle.
- `busy` = (state != IDLE).
- A `load_valid` asserted while not ready is not lost. It is held by the source under the valid/ready rules and accepted when ready rises.
- Reset is synchronous and takes priority over every other event, including mid-word:
  - state = IDLE; `shreg`, `cnt` = 0.
  - `sout` = 0, `sout_valid` = 0, `busy` = 0, `done` = 0.
  - `load_ready` = 1 on the first cycle after `rst` falls.
  - A partially sent word is discarded and is not resumed.

## Timing
- Handshake at edge N: bit `din[WIDTH-1]` appears in cycle N+1, and `din[0]` in cycle N+WIDTH.
- `done` is high in cycle N+WIDTH, or N+WIDTH+1 with parity.
- Back-to-back: a handshake on the final-bit cycle puts the next MSB in the very next cycle, with no gap in `sout_valid`.
- Throughput: one word per WIDTH cycles, or WIDTH+1 with parity.
- `sout`, `sout_valid`, `busy` and `done` are decoded from registered state only. There is no combinational path from the inputs to them.
- `load_ready` depends on state and `rst` only, not on `load_valid`.

## Configuration
- Macro `PISO_PARITY_EN`.
- Defined:
  - After the WIDTH payload bits, one extra cycle in PARITY drives `sout` = ^word, i.e. even parity computed over the word captured at load.
  - `sout_valid = 1` and `done = 1` during that cycle, and `load_ready = 1` there to allow back-to-back loads.
  - The parity bit is latched at load time.
- Undefined: the PARITY state, its register and the parity logic are absent, and the frame is exactly WIDTH bits.

## Structure
- Shared package `piso_pkg`:
  - State enum `piso_state_t` (IDLE, SHIFT, PARITY).
  - Constant `PISO_CNT_W(width)` as a function returning $clog2(width).
- Natural sub-module `piso_bit_counter`: a modulo-WIDTH counter with clear, enable and a `last` flag. The top-level file holds the FSM, the shift register and the parity logic.

## Test plan
- Reset, then load 4'b1100 with WIDTH=4 -> `sout` = 1,1,0,0 in cycles N+1..N+4; `done` only in N+4; `busy` then falls and `load_ready` = 1.
- Back-to-back 4'b1010 then 4'b0110, with the second load on the final-bit cycle -> 8 contiguous valid bits 1,0,1,0,0,1,1,0 and `done` in cycles N+4 and N+8.
- `load_valid` with 4'b1111 asserted during the second bit of 4'b0001 -> stream stays 0,0,0,1; 4'b1111 is accepted only on the final-bit cycle.
- `rst` asserted during the 3rd bit of 4'b1011 -> next cycle all outputs are 0, `load_ready` = 1 once `rst` drops, and no residual bits appear.
- Loopback into `shiftleftreg`, sending 4'b1100 -> receiver `out` = 4'b1100 after the 4th payload edge.
- `PISO_PARITY_EN` defined, sending 4'b1011 -> `sout` = 1,0,1,1 then parity bit 1; `done` on the 5th cycle; frame length is 5.
